// File: rtl/jesd204_rx_emb_link_ctrl.sv
// -----------------------------------------------------------------------------
// jesd204_rx_emb_link_ctrl
//
// Link bring-up sequencer for a 64b66b JESD204C receive link. It gathers the
// per-lane sync-header lock and extended-multiblock (EMB) lock, and resets the
// per-lane header framers on a timeout or a lock loss. Once every enabled lane
// holds EMB lock, it waits for a local extended-multiblock clock (LEMC) edge.
// It then counts a programmable number of beats and releases the lane elastic
// buffers.
//
// Ports
//   clk                       device clock, all logic on its rising edge
//   reset                     asynchronous, active-high
//   cfg_lanes_disable         1 = lane ignored; its lane_reset is held high
//   cfg_beats_per_multiframe  LEMC period in beats, minus 1
//   cfg_buffer_delay          beats from an LEMC edge to buffer release
//   cfg_lock_timeout          maximum beats spent in WAIT_EMB before a retry
//   phy_sh_lock               per-lane sync-header lock
//   lane_emb_lock             per-lane EMB lock from the header framer
//   lane_reset                per-lane header framer reset
//   lemc_edge                 1-beat pulse while the LEMC counter is 0
//   buffer_release            lane buffers may drain
//   link_up                   state is DATA
//   status_state              encoded current state (RESET=0 .. DATA=4)
//   event_lock_lost           1-beat pulse on a DATA -> RESET transition
//   retry_count               saturating count of returns to RESET
// -----------------------------------------------------------------------------
module jesd204_rx_emb_link_ctrl #(
  parameter int NUM_LANES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] cfg_lanes_disable,
  input  logic [7:0]           cfg_beats_per_multiframe,
  input  logic [7:0]           cfg_buffer_delay,
  input  logic [15:0]          cfg_lock_timeout,
  input  logic [NUM_LANES-1:0] phy_sh_lock,
  input  logic [NUM_LANES-1:0] lane_emb_lock,
  output logic [NUM_LANES-1:0] lane_reset,
  output logic                 lemc_edge,
  output logic                 buffer_release,
  output logic                 link_up,
  output logic [2:0]           status_state,
  output logic                 event_lock_lost,
  output logic [7:0]           retry_count
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_SH   = 3'd1,
    ST_WAIT_EMB  = 3'd2,
    ST_WAIT_LEMC = 3'd3,
    ST_DATA      = 3'd4
  } state_t;

  state_t         state_reg, state_next;
  logic [1:0]     rst_cnt_reg, rst_cnt_next;
  logic [15:0]    timeout_reg, timeout_next;
  logic [7:0]     delay_reg, delay_next;
  logic           armed_reg, armed_next;
  logic [7:0]     lemc_cnt_reg, lemc_cnt_next;
  logic [7:0]     retry_reg, retry_next;
  logic           retry_inc;
  logic           lock_lost;

  logic                 lemc_edge_reg;
  logic                 buffer_release_reg;
  logic                 link_up_reg;
  logic [2:0]           status_reg;
  logic                 event_lock_lost_reg;
  logic [NUM_LANES-1:0] lane_reset_reg;

  // A disabled lane always counts as locked, so it never blocks bring-up.
  logic [NUM_LANES-1:0] sh_ok;
  logic [NUM_LANES-1:0] emb_ok;
  logic                 all_sh;
  logic                 all_emb;
  logic                 any_enabled;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane_ok
      assign sh_ok[gi]  = phy_sh_lock[gi]   | cfg_lanes_disable[gi];
      assign emb_ok[gi] = lane_emb_lock[gi] | cfg_lanes_disable[gi];
    end
  endgenerate

  assign all_sh      = &sh_ok;
  assign all_emb     = &emb_ok;
  assign any_enabled = |(~cfg_lanes_disable);

  // Free-running LEMC counter. The >= compare means a period that has
  // shrunk below the current count wraps immediately instead of running
  // on to 255.
  always_comb begin
    lemc_cnt_next = lemc_cnt_reg + 8'd1;
    if (lemc_cnt_reg >= cfg_beats_per_multiframe) begin
      lemc_cnt_next = 8'd0;
    end
  end

  // Next-state logic. By default every helper counter and flag is cleared,
  // so each one only survives in the state that owns it.
  always_comb begin
    state_next   = state_reg;
    rst_cnt_next = 2'd0;
    timeout_next = 16'd0;
    delay_next   = 8'd0;
    armed_next   = 1'b0;
    retry_inc    = 1'b0;
    lock_lost    = 1'b0;

    case (state_reg)
      ST_RESET: begin
        rst_cnt_next = rst_cnt_reg + 2'd1;
        if (rst_cnt_reg == 2'd3) begin
          state_next = ST_WAIT_SH;
        end
      end

      ST_WAIT_SH: begin
        if (all_sh && any_enabled) begin
          state_next = ST_WAIT_EMB;
        end
      end

      ST_WAIT_EMB: begin
        timeout_next = timeout_reg + 16'd1;
        if (!all_sh) begin
          state_next = ST_WAIT_SH;
        end else if (all_emb) begin
          state_next = ST_WAIT_LEMC;
        end else if (timeout_reg == cfg_lock_timeout) begin
          state_next = ST_RESET;
          retry_inc  = 1'b1;
        end
      end

      ST_WAIT_LEMC: begin
        // The registered lemc_edge arms the release. The delay counts from
        // the beat after the edge, so DATA lands at edge + 2 + delay.
        armed_next = armed_reg | lemc_edge_reg;
        delay_next = armed_reg ? (delay_reg + 8'd1) : 8'd0;
        if (!all_emb || !all_sh) begin
          state_next = ST_RESET;
          retry_inc  = 1'b1;
        end else if (armed_reg && (delay_reg == cfg_buffer_delay)) begin
          state_next = ST_DATA;
        end
      end

      ST_DATA: begin
        if (!all_emb || !all_sh) begin
          state_next = ST_RESET;
          retry_inc  = 1'b1;
          lock_lost  = 1'b1;
        end
      end

      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

  always_comb begin
    retry_next = retry_reg;
    if (retry_inc && (retry_reg != 8'hFF)) begin
      retry_next = retry_reg + 8'd1;
    end
  end

  // Core state and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_RESET;
      rst_cnt_reg  <= 2'd0;
      timeout_reg  <= 16'd0;
      delay_reg    <= 8'd0;
      armed_reg    <= 1'b0;
      lemc_cnt_reg <= 8'd0;
      retry_reg    <= 8'd0;
    end else begin
      state_reg    <= state_next;
      rst_cnt_reg  <= rst_cnt_next;
      timeout_reg  <= timeout_next;
      delay_reg    <= delay_next;
      armed_reg    <= armed_next;
      lemc_cnt_reg <= lemc_cnt_next;
      retry_reg    <= retry_next;
    end
  end

  // The output registers are loaded from next-state values. Each output
  // therefore changes on the same edge as the state it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lemc_edge_reg       <= 1'b0;
      buffer_release_reg  <= 1'b0;
      link_up_reg         <= 1'b0;
      status_reg          <= 3'd0;
      event_lock_lost_reg <= 1'b0;
    end else begin
      lemc_edge_reg       <= (lemc_cnt_next == 8'd0);
      buffer_release_reg  <= (state_next == ST_DATA);
      link_up_reg         <= (state_next == ST_DATA);
      status_reg          <= state_next;
      event_lock_lost_reg <= lock_lost;
    end
  end

  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane_reset
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lane_reset_reg[gi] <= 1'b1;
        end else begin
          lane_reset_reg[gi] <= (state_next == ST_RESET) | cfg_lanes_disable[gi];
        end
      end
    end
  endgenerate

  assign lane_reset      = lane_reset_reg;
  assign lemc_edge       = lemc_edge_reg;
  assign buffer_release  = buffer_release_reg;
  assign link_up         = link_up_reg;
  assign status_state    = status_reg;
  assign event_lock_lost = event_lock_lost_reg;
  assign retry_count     = retry_reg;

endmodule

// File: tb/tb_jesd204_rx_emb_link_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for jesd204_rx_emb_link_ctrl.
// Before applying each stimulus, the stimulus process pushes the state
// transitions it expects into a queue. A monitor detects every change of
// status_state, pops the next expected record, and compares the DUT outputs
// and the time spent since a reference point against that record. Checks
// with no matching state change are done inline.
// -----------------------------------------------------------------------------
module tb_jesd204_rx_emb_link_ctrl;

  localparam int NL = 4;
  localparam int REF_CHG  = 0;  // beats since the previous state change
  localparam int REF_MARK = 1;  // beats since the stimulus mark
  localparam int REF_EDGE = 2;  // beats since the first lemc_edge in WAIT_LEMC

  logic          clk = 1'b0;
  logic          reset;
  logic [NL-1:0] cfg_lanes_disable;
  logic [7:0]    cfg_beats_per_multiframe;
  logic [7:0]    cfg_buffer_delay;
  logic [15:0]   cfg_lock_timeout;
  logic [NL-1:0] sh_base, emb_base;
  logic          tog_sh, tog_emb;
  logic [NL-1:0] phy_sh_lock, lane_emb_lock;
  logic [NL-1:0] lane_reset;
  logic          lemc_edge, buffer_release, link_up, event_lock_lost;
  logic [2:0]    status_state;
  logic [7:0]    retry_count;

  // Lane 3 can be toggled randomly on top of its base value.
  assign phy_sh_lock   = {sh_base[3]  ^ tog_sh,  sh_base[2:0]};
  assign lane_emb_lock = {emb_base[3] ^ tog_emb, emb_base[2:0]};

  jesd204_rx_emb_link_ctrl #(.NUM_LANES(NL)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .cfg_lanes_disable        (cfg_lanes_disable),
    .cfg_beats_per_multiframe (cfg_beats_per_multiframe),
    .cfg_buffer_delay         (cfg_buffer_delay),
    .cfg_lock_timeout         (cfg_lock_timeout),
    .phy_sh_lock              (phy_sh_lock),
    .lane_emb_lock            (lane_emb_lock),
    .lane_reset               (lane_reset),
    .lemc_edge                (lemc_edge),
    .buffer_release           (buffer_release),
    .link_up                  (link_up),
    .status_state             (status_state),
    .event_lock_lost          (event_lock_lost),
    .retry_count              (retry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    st;
    logic [7:0]    retry;
    logic [NL-1:0] lrst;
    logic          ell;
    int            ref_kind;
    int            dt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ncyc = 0;
  int   mark_cyc = 0;
  bit   dis_test = 1'b0;

  task automatic push(input logic [2:0] st, input int retry, input logic [NL-1:0] lrst,
                      input logic ell, input int ref_kind, input int dt);
    exp_t e;
    e.st = st;
    e.retry = (retry > 255) ? 8'd255 : 8'(retry);
    e.lrst = lrst;
    e.ell = ell;
    e.ref_kind = ref_kind;
    e.dt = dt;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Block until the monitor has consumed every queued record, with a bound.
  // Returns 1 ns after a falling edge.
  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d transitions still pending after %0d beats, required 0",
               sb.size(), max_cyc);
      sb.delete();
    end
  endtask

  // Monitor: every state change is one transaction.
  initial begin : monitor
    int          last_chg;
    int          edge_cyc;
    bit          edge_seen;
    logic [2:0]  prev_st;
    exp_t        e;
    int          dt_act;
    int          refc;
    last_chg = 0;
    edge_cyc = 0;
    edge_seen = 1'b0;
    prev_st = 3'd0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (reset) begin
        prev_st = 3'd0;
        last_chg = ncyc;
        edge_seen = 1'b0;
      end else begin
        if (status_state == 3'd3 && lemc_edge && !edge_seen) begin
          edge_seen = 1'b1;
          edge_cyc = ncyc;
        end
        if (status_state != prev_st) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_transition: got state %0d -> %0d at beat %0d, required none",
                     prev_st, status_state, ncyc);
          end else begin
            e = sb.pop_front();
            refc = (e.ref_kind == REF_CHG) ? last_chg :
                   (e.ref_kind == REF_MARK) ? mark_cyc : edge_cyc;
            dt_act = (e.ref_kind == REF_EDGE && !edge_seen) ? -1 : ncyc - refc;
            if (status_state !== e.st || retry_count !== e.retry || lane_reset !== e.lrst ||
                event_lock_lost !== e.ell || buffer_release !== (e.st == 3'd4) ||
                link_up !== (e.st == 3'd4) || dt_act != e.dt) begin
              miscompares++;
              $display("FAIL transition_to_%0d: got st=%0d retry=%0d lrst=%b ell=%0d br=%0d lu=%0d dt=%0d, required st=%0d retry=%0d lrst=%b ell=%0d br=lu=%0d dt=%0d",
                       e.st, status_state, retry_count, lane_reset, event_lock_lost,
                       buffer_release, link_up, dt_act, e.st, e.retry, e.lrst, e.ell,
                       (e.st == 3'd4), e.dt);
            end
          end
          prev_st = status_state;
          last_chg = ncyc;
        end
        if (status_state != 3'd3) edge_seen = 1'b0;
      end
    end
  end

  // Random toggling of lane 3 while it is disabled; its reset must stay high.
  initial begin : lane3_toggler
    tog_sh = 1'b0;
    tog_emb = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (dis_test) begin
        tog_sh  = 1'($urandom_range(0, 1));
        tog_emb = 1'($urandom_range(0, 1));
        check("lane3_reset_held", int'(lane_reset[3]), 1);
      end else begin
        tog_sh  = 1'b0;
        tog_emb = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int n;
    reset = 1'b1;
    cfg_lanes_disable = '0;
    cfg_beats_per_multiframe = 8'd31;
    cfg_buffer_delay = 8'd5;
    cfg_lock_timeout = 16'd100;
    sh_base = '0;
    emb_base = '0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_lane_reset", int'(lane_reset), 15);
    check("rst_retry", int'(retry_count), 0);
    check("rst_state", int'(status_state), 0);
    check("rst_lemc_edge", int'(lemc_edge), 0);
    check("rst_buffer_release", int'(buffer_release), 0);
    check("rst_link_up", int'(link_up), 0);
    check("rst_lock_lost", int'(event_lock_lost), 0);

    // Bring-up with all lanes locked. DATA comes 7 beats after the first edge.
    sh_base = '1;
    emb_base = '1;
    push(3'd1, 0, 4'b0000, 1'b0, REF_CHG, 4);
    push(3'd2, 0, 4'b0000, 1'b0, REF_CHG, 1);
    push(3'd3, 0, 4'b0000, 1'b0, REF_CHG, 1);
    push(3'd4, 0, 4'b0000, 1'b0, REF_EDGE, 7);
    reset = 1'b0;
    drain(200);

    // Lock loss in DATA, followed by a relock
    repeat (5) @(negedge clk);
    #1;
    mark_cyc = ncyc;
    emb_base[1] = 1'b0;
    push(3'd0, 1, 4'b1111, 1'b1, REF_MARK, 1);
    push(3'd1, 1, 4'b0000, 1'b0, REF_CHG, 4);
    push(3'd2, 1, 4'b0000, 1'b0, REF_CHG, 1);
    push(3'd3, 1, 4'b0000, 1'b0, REF_CHG, 1);
    push(3'd4, 1, 4'b0000, 1'b0, REF_EDGE, 7);
    @(negedge clk);
    #1;
    emb_base[1] = 1'b1;
    @(negedge clk);
    #1;
    check("lock_lost_one_beat", int'(event_lock_lost), 0);
    check("lock_lost_buffer_release", int'(buffer_release), 0);
    drain(200);

    // Timeout: lane 2 loses EMB lock, so WAIT_EMB expires after 101 beats
    repeat (3) @(negedge clk);
    #1;
    mark_cyc = ncyc;
    emb_base[2] = 1'b0;
    push(3'd0, 2, 4'b1111, 1'b1, REF_MARK, 1);
    push(3'd1, 2, 4'b0000, 1'b0, REF_CHG, 4);
    push(3'd2, 2, 4'b0000, 1'b0, REF_CHG, 1);
    push(3'd0, 3, 4'b1111, 1'b0, REF_CHG, 101);
    push(3'd1, 3, 4'b0000, 1'b0, REF_CHG, 4);
    push(3'd2, 3, 4'b0000, 1'b0, REF_CHG, 1);
    drain(400);

    // Sync-header drop in WAIT_EMB goes to WAIT_SH without a retry
    repeat (10) @(negedge clk);
    #1;
    mark_cyc = ncyc;
    sh_base[0] = 1'b0;
    push(3'd1, 3, 4'b0000, 1'b0, REF_MARK, 1);
    drain(20);

    // With every lane disabled, the block stays in WAIT_SH
    cfg_lanes_disable = '1;
    sh_base = '1;
    repeat (20) @(negedge clk);
    #1;
    check("all_disabled_state", int'(status_state), 1);
    check("all_disabled_lane_reset", int'(lane_reset), 15);
    check("all_disabled_retry", int'(retry_count), 3);

    // Re-enable the lanes, then repeat timeouts until retry_count saturates
    mark_cyc = ncyc;
    cfg_lanes_disable = '0;
    push(3'd2, 3, 4'b0000, 1'b0, REF_MARK, 1);
    push(3'd0, 4, 4'b1111, 1'b0, REF_CHG, 101);
    for (int r = 5; r <= 302; r++) begin
      push(3'd1, r - 1, 4'b0000, 1'b0, REF_CHG, 4);
      push(3'd2, r - 1, 4'b0000, 1'b0, REF_CHG, 1);
      push(3'd0, r, 4'b1111, 1'b0, REF_CHG, 101);
    end
    drain(40000);
    check("retry_saturated", int'(retry_count), 255);

    // Disabled lane 3 toggles randomly; the link still comes up
    cfg_lanes_disable = 4'b1000;
    emb_base[2] = 1'b1;
    dis_test = 1'b1;
    push(3'd1, 255, 4'b1000, 1'b0, REF_CHG, 4);
    push(3'd2, 255, 4'b1000, 1'b0, REF_CHG, 1);
    push(3'd3, 255, 4'b1000, 1'b0, REF_CHG, 1);
    push(3'd4, 255, 4'b1000, 1'b0, REF_EDGE, 7);
    drain(200);
    repeat (10) @(negedge clk);
    dis_test = 1'b0;
    check("disabled_link_up", int'(link_up), 1);

    // Asynchronous reset between clock edges while in DATA
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_lane_reset", int'(lane_reset), 15);
    check("async_state", int'(status_state), 0);
    check("async_link_up", int'(link_up), 0);
    check("async_buffer_release", int'(buffer_release), 0);
    check("async_retry", int'(retry_count), 0);
    check("async_lemc_edge", int'(lemc_edge), 0);
    check("async_lock_lost", int'(event_lock_lost), 0);
    @(negedge clk);
    #1;
    push(3'd1, 0, 4'b1000, 1'b0, REF_CHG, 4);
    push(3'd2, 0, 4'b1000, 1'b0, REF_CHG, 1);
    push(3'd3, 0, 4'b1000, 1'b0, REF_CHG, 1);
    push(3'd4, 0, 4'b1000, 1'b0, REF_EDGE, 7);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (lemc_edge) break;
    end
    check("lemc_restart_period", n, 32);
    #1;
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
